spi_slave_port: RTL

- SPI slave endpoint that consumes the Master's sclk, CSxbar, MOSI and sMODE outputs and drives MISO back to it.
- Runs on its own system clock `clk` and treats sclk/csbar/mosi as asynchronous inputs, using synchronisers and edge detection.
- Exposes a byte-wide receive strobe and a valid/ready transmit buffer to local slave logic.
- One instance per chip select (CS1bar/CS2bar/CS3bar).

---
 rtl/spi_slave_port.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_port.sv
// SPI slave endpoint: synchronises sclk/csbar/mosi into clk, receives LSB-first, transmits MSB-first.
// Optional overrun/underrun status ports and rx_ack input are built when SPI_SLAVE_STATUS_EN is defined.
`timescale 1ns/1ps
module spi_slave_port #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  IDLE_TX_BYTE = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sclk,
  input  logic       i_csbar,
  input  logic       i_mosi,
  input  logic [1:0] i_mode,
  output logic       o_miso,
  output logic       o_miso_oe,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  input  logic       i_rx_ack,
  output logic       o_overrun,
  output logic       o_underrun
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d;
  state_t                 r_state;
  logic [1:0]             r_mode;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx_shift;
  logic [7:0]             r_tx_shift, r_hold, r_rx_data;
  logic                   r_tx_ready, r_rx_valid, r_miso_oe, r_busy;
  logic                   r_reload_pend, r_skip;

  logic       w_sclk_s, w_cs_s, w_mosi_s, w_rise, w_fall, w_sample_on_rise;
  logic       w_sample, w_shift, w_tx_fire, w_reload;
  logic [7:0] w_next_byte, w_rx_next;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sclk_sync <= {SYNC_STAGES{i_mode[1]}};
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= i_mode[1];
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_csbar};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_rise           = w_sclk_s & ~r_sclk_d;
  assign w_fall           = ~w_sclk_s & r_sclk_d;
  assign w_sample_on_rise = ~(r_mode[1] ^ r_mode[0]);
  assign w_sample         = w_sample_on_rise ? w_rise : w_fall;
  assign w_shift          = w_sample_on_rise ? w_fall : w_rise;
  assign w_rx_next        = {w_mosi_s, r_rx_shift};

  // An empty holding register with a handshake this clk forwards tx_data straight into the shifter.
  assign w_tx_fire   = i_tx_valid & r_tx_ready;
  assign w_next_byte = !r_tx_ready ? r_hold : (i_tx_valid ? i_tx_data : IDLE_TX_BYTE);
  assign w_reload    = !w_cs_s && ((r_state == StLoad) ||
                       (r_state == StShift && w_shift && r_reload_pend && !r_skip));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_mode        <= 2'd0;
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 7'd0;
      r_tx_shift    <= 8'd0;
      r_hold        <= 8'd0;
      r_rx_data     <= 8'd0;
      r_tx_ready    <= 1'b1;
      r_rx_valid    <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_busy        <= 1'b0;
      r_reload_pend <= 1'b0;
      r_skip        <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_reload) begin
        r_tx_ready <= 1'b1;
      end else if (w_tx_fire) begin
        r_hold     <= i_tx_data;
        r_tx_ready <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          r_miso_oe     <= 1'b0;
          r_busy        <= 1'b0;
          r_bit_cnt     <= 3'd0;
          r_reload_pend <= 1'b0;
          r_skip        <= 1'b0;
          r_mode        <= i_mode;
          if (!w_cs_s) r_state <= StLoad;
        end
        StLoad: begin
          if (w_cs_s) begin
            r_state <= StIdle;
          end else begin
            r_mode     <= i_mode;
            r_tx_shift <= w_next_byte;
            // With CPHA=1 the first leading edge must leave bit 7 on miso.
            r_skip     <= i_mode[0];
            r_miso_oe  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StShift;
          end
        end
        StShift: begin
          if (w_cs_s) begin
            r_state       <= StIdle;
            r_miso_oe     <= 1'b0;
            r_busy        <= 1'b0;
            r_bit_cnt     <= 3'd0;
            r_reload_pend <= 1'b0;
          end else begin
            if (w_sample) begin
              r_rx_shift <= w_rx_next[7:1];
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_rx_data     <= w_rx_next;
                r_rx_valid    <= 1'b1;
                r_reload_pend <= 1'b1;
              end
            end
            if (w_shift) begin
              if (r_skip) begin
                r_skip <= 1'b0;
              end else if (r_reload_pend) begin
                r_tx_shift    <= w_next_byte;
                r_reload_pend <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_miso     = r_tx_shift[7];
  assign o_miso_oe  = r_miso_oe;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_tx_ready = r_tx_ready;
  assign o_busy     = r_busy;

`ifdef SPI_SLAVE_STATUS_EN
  logic r_rx_pending, r_overrun, r_underrun;
  logic w_byte_done;

  assign w_byte_done = (r_state == StShift) && !w_cs_s && w_sample && (r_bit_cnt == 3'd7);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_pending <= 1'b0;
      r_overrun    <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_byte_done) r_rx_pending <= 1'b1;
      else if (i_rx_ack) r_rx_pending <= 1'b0;
      if (w_byte_done && r_rx_pending && !i_rx_ack) r_overrun <= 1'b1;
      else if (i_rx_ack) r_overrun <= 1'b0;
      if (w_reload && r_tx_ready && !i_tx_valid) r_underrun <= 1'b1;
      else if (w_tx_fire) r_underrun <= 1'b0;
    end
  end

  assign o_overrun  = r_overrun;
  assign o_underrun = r_underrun;
`endif

endmodule
